// File: rtl/soc_pkg.sv
// Shared SoC types: AXI master request/response structs, boot sequencer states and
// default addresses/values for the RAM configuration writes.
package soc_pkg;

    localparam int unsigned AXI_ID_W       = 4;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [63:0]         addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
    } axi_ax_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [63:0]         data;
        logic [1:0]          resp;
        logic                last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } m_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        axi_b_t  b;
        logic    b_valid;
        logic    ar_ready;
        axi_r_t  r;
        logic    r_valid;
    } m_resp_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CFG_FREQ  = 3'd1,
        CFG_CLKEN = 3'd2,
        STREAM    = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } boot_state_e;

    localparam logic [63:0] RAM_FREQ_ADDR_DEF  = 64'h0000_0000_1000_0600;
    localparam logic [63:0] RAM_FREQ_VAL_DEF   = 64'd3200;
    localparam logic [63:0] RAM_CLKEN_ADDR_DEF = 64'h0000_0000_1000_0E18;

endpackage

// File: rtl/boot_sequencer_if.sv
// One-word (address, data, last) valid/ready handshake used by the image source
// and by the sequencer to feed its write issue stage.
interface boot_sequencer_if;
    logic        valid;
    logic        ready;
    logic [63:0] addr;
    logic [63:0] data;
    logic        last;

    modport master (output valid, addr, data, last, input ready);
    modport slave  (input valid, addr, data, last, output ready);
endinterface

// File: rtl/boot_axi_wr_issue.sv
// Single-word AXI write issue stage: AW and W handshake independently and the word
// retires in the cycle the later of the two completes.
module boot_axi_wr_issue (
    input  logic                   clk_i,
    input  logic                   arst_i,
    boot_sequencer_if.slave        word_if,
    output logic                   aw_valid_o,
    input  logic                   aw_ready_i,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    output logic [63:0]            addr_o,
    output logic [63:0]            data_o,
    output logic                   last_o,
    output logic                   aw_fire_o,
    output logic                   retire_o
);
    logic        full_q, full_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [63:0] addr_q, data_q;
    logic        last_q;
    logic        accept, w_fire;

    assign word_if.ready = ~full_q;
    assign accept        = word_if.valid & ~full_q;
    assign aw_valid_o    = full_q & ~aw_done_q;
    assign w_valid_o     = full_q & ~w_done_q;
    assign aw_fire_o     = aw_valid_o & aw_ready_i;
    assign w_fire        = w_valid_o & w_ready_i;
    assign retire_o      = full_q & (aw_done_q | aw_fire_o) & (w_done_q | w_fire);
    assign addr_o        = addr_q;
    assign data_o        = data_q;
    assign last_o        = last_q;

    always_comb begin
        full_d    = full_q;
        aw_done_d = aw_done_q | aw_fire_o;
        w_done_d  = w_done_q | w_fire;
        if (retire_o) begin
            full_d    = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else if (accept) begin
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            full_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            full_q    <= full_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (accept) begin
                addr_q <= word_if.addr;
                data_q <= word_if.data;
                last_q <= word_if.last;
            end
        end
    end
endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: programs the RAM frequency and clock-enable registers, then streams
// (address, data) words from mass storage into RAM with several AXI writes in flight.
module boot_sequencer
    import soc_pkg::*;
#(
    parameter type         req_t           = soc_pkg::m_req_t,
    parameter type         resp_t          = soc_pkg::m_resp_t,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [63:0] RAM_FREQ_ADDR   = soc_pkg::RAM_FREQ_ADDR_DEF,
    parameter logic [63:0] RAM_FREQ_VAL    = soc_pkg::RAM_FREQ_VAL_DEF,
    parameter logic [63:0] RAM_CLKEN_ADDR  = soc_pkg::RAM_CLKEN_ADDR_DEF,
    parameter int unsigned AXI_ID          = 0
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        start_i,
    input  logic        src_valid_i,
    output logic        src_ready_o,
    input  logic [63:0] src_addr_i,
    input  logic [63:0] src_data_i,
    input  logic        src_last_i,
    output req_t        m_req_o,
    input  resp_t       m_resp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] words_o
);
    boot_state_e state_q, state_d;
    logic [3:0]  outst_q, outst_d;
    logic [31:0] words_q, words_d;
    logic        err_q, err_d;
    logic        cfg_sent_q, cfg_sent_d;

    logic        busy, b_fire, stream_aw;
    logic        aw_valid, w_valid, aw_fire, retire, iss_last;
    logic [63:0] iss_addr, iss_data;
    logic        unused_resp;

    boot_sequencer_if iss_if ();

    boot_axi_wr_issue u_issue (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .word_if    (iss_if.slave),
        .aw_valid_o (aw_valid),
        .aw_ready_i (m_resp_i.aw_ready),
        .w_valid_o  (w_valid),
        .w_ready_i  (m_resp_i.w_ready),
        .addr_o     (iss_addr),
        .data_o     (iss_data),
        .last_o     (iss_last),
        .aw_fire_o  (aw_fire),
        .retire_o   (retire)
    );

    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign b_fire      = m_resp_i.b_valid & busy;
    assign stream_aw   = aw_fire & (state_q == STREAM);
    assign src_ready_o = (state_q == STREAM) & iss_if.ready & (32'(outst_q) < MAX_OUTSTANDING);
    assign busy_o      = busy;
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign words_o     = words_q;
    assign unused_resp = ^{m_resp_i.ar_ready, m_resp_i.r_valid, m_resp_i.r, m_resp_i.b.id};

    always_comb begin
        state_d      = state_q;
        outst_d      = outst_q;
        words_d      = words_q;
        err_d        = err_q;
        cfg_sent_d   = cfg_sent_q;
        iss_if.valid = 1'b0;
        iss_if.addr  = '0;
        iss_if.data  = '0;
        iss_if.last  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    err_d      = 1'b0;
                    words_d    = '0;
                    cfg_sent_d = 1'b0;
                    state_d    = CFG_FREQ;
                end
            end
            CFG_FREQ, CFG_CLKEN: begin
                iss_if.valid = ~cfg_sent_q;
                iss_if.addr  = (state_q == CFG_FREQ) ? RAM_FREQ_ADDR : RAM_CLKEN_ADDR;
                iss_if.data  = (state_q == CFG_FREQ) ? RAM_FREQ_VAL : 64'd1;
                if (iss_if.ready && !cfg_sent_q) cfg_sent_d = 1'b1;
                if (b_fire) begin
                    cfg_sent_d = 1'b0;
                    state_d    = (state_q == CFG_FREQ) ? CFG_CLKEN : STREAM;
                end
            end
            STREAM: begin
                iss_if.valid = src_valid_i & src_ready_o;
                iss_if.addr  = {src_addr_i[63:3], 3'b000};
                iss_if.data  = src_data_i;
                iss_if.last  = src_last_i;
                if (iss_if.valid && (src_addr_i[2:0] != 3'b000)) err_d = 1'b1;
                if (retire && iss_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (outst_q == '0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (b_fire && (m_resp_i.b.resp != AXI_RESP_OKAY)) err_d = 1'b1;
        // Config writes complete in CFG_* states, so only stream B's reach the counters.
        if ((state_q == STREAM) || (state_q == DRAIN)) begin
            if (stream_aw && !b_fire) outst_d = outst_q + 4'd1;
            if (!stream_aw && b_fire) outst_d = outst_q - 4'd1;
            if (b_fire) words_d = words_q + 32'd1;
        end
    end

    always_comb begin
        m_req_o          = '0;
        m_req_o.aw.id    = AXI_ID_W'(AXI_ID);
        m_req_o.aw.addr  = iss_addr;
        m_req_o.aw.len   = '0;
        m_req_o.aw.size  = 3'd3;
        m_req_o.aw.burst = AXI_BURST_INCR;
        m_req_o.aw_valid = aw_valid;
        m_req_o.w.data   = iss_data;
        m_req_o.w.strb   = '1;
        m_req_o.w.last   = 1'b1;
        m_req_o.w_valid  = w_valid;
        m_req_o.b_ready  = busy;
        m_req_o.ar_valid = 1'b0;
        m_req_o.r_ready  = 1'b0;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            outst_q    <= '0;
            words_q    <= '0;
            err_q      <= 1'b0;
            cfg_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            outst_q    <= outst_d;
            words_q    <= words_d;
            err_q      <= err_d;
            cfg_sent_q <= cfg_sent_d;
        end
    end
endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboard bench for boot_sequencer: an AXI slave/monitor process checks every
// write against the queue of expected writes pushed by the stimulus process.
module tb_boot_sequencer;
    import soc_pkg::*;

    localparam int unsigned MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        arst_i, start_i;
    logic        busy_o, done_o, err_o;
    logic [31:0] words_o;
    m_req_t      m_req;
    m_resp_t     m_resp;

    boot_sequencer_if src_if ();

    boot_sequencer #(
        .MAX_OUTSTANDING (MAX_OUT),
        .AXI_ID          (0)
    ) dut (
        .clk_i       (clk),
        .arst_i      (arst_i),
        .start_i     (start_i),
        .src_valid_i (src_if.valid),
        .src_ready_o (src_if.ready),
        .src_addr_i  (src_if.addr),
        .src_data_i  (src_if.data),
        .src_last_i  (src_if.last),
        .m_req_o     (m_req),
        .m_resp_i    (m_resp),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .words_o     (words_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // slave configuration (written by stimulus only)
    int unsigned aw_lat = 0, w_lat = 0, b_lat = 0;
    int          err_idx = -1;
    int unsigned run_no = 0;

    // slave/monitor state (written by monitor only)
    logic        aw_ready = 0, w_ready = 0, b_valid = 0;
    logic [1:0]  b_resp_cur = 2'b00;
    int unsigned cyc = 0, aw_cnt = 0, w_cnt = 0, seen_run = 0;
    int          inflight = 0, peak = 0, ready_viol = 0;
    int          b_cnt_run = 0, aw_hs_run = 0, w_hs_run = 0, wr_idx = 0;
    int unsigned last_aw_cyc = 0, last_w_cyc = 0;
    logic [63:0] aw_q[$], w_q[$];
    int unsigned b_due_q[$];
    logic [1:0]  b_resp_q[$];

    // expected writes (pushed by stimulus, popped by monitor)
    logic [63:0] exp_addr_q[$], exp_data_q[$];

    always_comb begin
        m_resp          = '0;
        m_resp.aw_ready = aw_ready;
        m_resp.w_ready  = w_ready;
        m_resp.b_valid  = b_valid;
        m_resp.b.resp   = b_resp_cur;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] a, d;
        cyc++;
        if (arst_i) begin
            aw_q.delete(); w_q.delete(); b_due_q.delete(); b_resp_q.delete();
            exp_addr_q.delete(); exp_data_q.delete();
            aw_ready = 0; w_ready = 0; b_valid = 0; b_resp_cur = 2'b00;
            aw_cnt = 0; w_cnt = 0; inflight = 0;
        end else begin
            if (seen_run != run_no) begin
                seen_run = run_no;
                b_cnt_run = 0; aw_hs_run = 0; w_hs_run = 0; wr_idx = 0;
                peak = 0; ready_viol = 0;
            end
            if (src_if.ready && inflight >= int'(MAX_OUT)) ready_viol++;
            aw_ready = m_req.aw_valid && (aw_cnt >= aw_lat);
            w_ready  = m_req.w_valid && (w_cnt >= w_lat);
            if (m_req.aw_valid && !aw_ready) aw_cnt++;
            if (m_req.w_valid && !w_ready) w_cnt++;
            if (aw_ready) begin
                aw_cnt = 0; aw_hs_run++; inflight++; last_aw_cyc = cyc;
                aw_q.push_back(m_req.aw.addr);
                check("aw_fields", 64'({m_req.aw.len, m_req.aw.size, m_req.aw.burst, m_req.aw.id}),
                      64'({8'd0, 3'd3, 2'b01, 4'd0}));
                if (m_req.aw.addr == 64'h1000_0E18) check("clken_after_freq_b", 64'(b_cnt_run), 64'd1);
            end
            if (w_ready) begin
                w_cnt = 0; w_hs_run++; last_w_cyc = cyc;
                w_q.push_back(m_req.w.data);
                check("w_fields", 64'({m_req.w.strb, m_req.w.last}), 64'({8'hff, 1'b1}));
            end
            while (aw_q.size() > 0 && w_q.size() > 0) begin
                a = aw_q.pop_front();
                d = w_q.pop_front();
                if (exp_addr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write actual=%0h/%0h required=none", a, d);
                end else begin
                    check("wr_addr", a, exp_addr_q.pop_front());
                    check("wr_data", d, exp_data_q.pop_front());
                end
                b_due_q.push_back(cyc + 1 + b_lat);
                b_resp_q.push_back((wr_idx == err_idx) ? 2'b10 : 2'b00);
                wr_idx++;
            end
            b_valid    = (b_due_q.size() > 0) && (b_due_q[0] <= cyc);
            b_resp_cur = b_valid ? b_resp_q[0] : 2'b00;
            if (b_valid && m_req.b_ready) begin
                void'(b_due_q.pop_front());
                void'(b_resp_q.pop_front());
                b_cnt_run++; inflight--;
            end
            if (inflight > peak) peak = inflight;
        end
    end

    task automatic set_slave(input int unsigned awl, input int unsigned wl, input int unsigned bl, input int ei);
        aw_lat = awl; w_lat = wl; b_lat = bl; err_idx = ei;
    endtask

    task automatic run_start();
        @(negedge clk);
        run_no++;
        exp_addr_q.push_back(64'h1000_0600); exp_data_q.push_back(64'd3200);
        exp_addr_q.push_back(64'h1000_0E18); exp_data_q.push_back(64'd1);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", 64'(busy_o), 64'd1);
        check("cleared_after_start", 64'({done_o, err_o, words_o}), 64'd0);
    endtask

    task automatic send_word(input logic [63:0] a, input logic [63:0] d, input logic l);
        bit ok = 0;
        exp_addr_q.push_back(a & ~64'h7);
        exp_data_q.push_back(d);
        src_if.valid = 1'b1; src_if.addr = a; src_if.data = d; src_if.last = l;
        for (int i = 0; i < 2000 && !ok; i++) begin
            ok = src_if.ready;
            @(negedge clk);
        end
        src_if.valid = 1'b0; src_if.last = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL src_accept_timeout actual=no_ready required=ready addr=%0h", a);
        end
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            seen = done_o;
        end
        check("done_reached", 64'(seen), 64'd1);
    endtask

    task automatic check_sb_empty(input string name);
        check(name, 64'(exp_addr_q.size() + aw_q.size() + w_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        arst_i = 1'b0; start_i = 1'b0;
        src_if.valid = 1'b0; src_if.addr = '0; src_if.data = '0; src_if.last = 1'b0;
        #1 arst_i = 1'b1;
        #2;
        check("rst_status", 64'({busy_o, done_o, err_o, words_o}), 64'd0);
        check("rst_handshakes", 64'({src_if.ready, m_req.aw_valid, m_req.w_valid, m_req.b_ready,
                                     m_req.ar_valid, m_req.r_ready}), 64'd0);
        repeat (2) @(negedge clk);
        arst_i = 1'b0;

        // config sequence plus three-word image, zero-latency slave
        set_slave(0, 0, 0, -1);
        run_start();
        send_word(64'h8000_0000, 64'd1, 1'b0);
        send_word(64'h8000_0008, 64'd2, 1'b0);
        send_word(64'h8000_0010, 64'd3, 1'b1);
        wait_done();
        check("t1_bcount_at_done", 64'(b_cnt_run), 64'd5);
        check("t1_writes", 64'(aw_hs_run), 64'd5);
        check("t1_words", 64'(words_o), 64'd3);
        check("t1_err", 64'(err_o), 64'd0);
        check("t1_busy", 64'(busy_o), 64'd0);
        check_sb_empty("t1_sb_empty");

        // slow B: outstanding limit throttles the source
        set_slave(0, 0, 20, -1);
        run_start();
        for (int i = 0; i < 10; i++)
            send_word(64'h8000_1000 + 64'(8 * i), 64'd100 + 64'(i), (i == 9));
        wait_done();
        check("t2_peak_outstanding", 64'(peak), 64'd4);
        check("t2_ready_while_full", 64'(ready_viol), 64'd0);
        check("t2_words", 64'(words_o), 64'd10);
        check_sb_empty("t2_sb_empty");

        // W accepted well before AW: exactly one write, no re-issue
        set_slave(5, 0, 0, -1);
        run_start();
        send_word(64'h8000_2000, 64'hABCD, 1'b1);
        wait_done();
        check("t3_aw_minus_w_cycles", 64'(last_aw_cyc - last_w_cyc), 64'd5);
        check("t3_aw_count", 64'(aw_hs_run), 64'd3);
        check("t3_w_count", 64'(w_hs_run), 64'd3);
        check("t3_words", 64'(words_o), 64'd1);
        check_sb_empty("t3_sb_empty");

        // SLVERR on stream word 2 of 4 (write index 3 counting the config writes)
        set_slave(0, 0, 0, 3);
        run_start();
        for (int i = 0; i < 4; i++)
            send_word(64'h8000_3000 + 64'(8 * i), 64'h55 + 64'(i), (i == 3));
        wait_done();
        check("t4_err_sticky", 64'(err_o), 64'd1);
        check("t4_words", 64'(words_o), 64'd4);
        check("t4_done", 64'(done_o), 64'd1);
        check_sb_empty("t4_sb_empty");

        // misaligned source address: aligned write issued, err raised
        set_slave(0, 0, 0, -1);
        run_start();
        send_word(64'h8000_4003, 64'h77, 1'b1);
        wait_done();
        check("t5_err_misaligned", 64'(err_o), 64'd1);
        check("t5_words", 64'(words_o), 64'd1);
        check_sb_empty("t5_sb_empty");

        // reset in STREAM with two writes outstanding, then a fresh run
        set_slave(0, 0, 20, -1);
        run_start();
        send_word(64'h8000_5000, 64'h1, 1'b0);
        send_word(64'h8000_5008, 64'h2, 1'b0);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = (inflight == 2);
        end
        check("t6_two_outstanding", 64'(hit), 64'd1);
        @(posedge clk);
        #2 arst_i = 1'b1;
        #1;
        check("t6_rst_status", 64'({busy_o, done_o, err_o, words_o}), 64'd0);
        check("t6_rst_handshakes", 64'({src_if.ready, m_req.aw_valid, m_req.w_valid, m_req.b_ready}), 64'd0);
        repeat (3) @(negedge clk);
        arst_i = 1'b0;
        set_slave(0, 0, 0, -1);
        @(negedge clk);
        run_start();
        send_word(64'h8000_6000, 64'h99, 1'b1);
        wait_done();
        check("t6_rerun_writes", 64'(aw_hs_run), 64'd3);
        check("t6_rerun_words", 64'(words_o), 64'd1);
        check("t6_rerun_err", 64'(err_o), 64'd0);
        check_sb_empty("t6_sb_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
